// File: rtl/demux32_reg.sv
// Registered 1-to-4 demultiplexer for 32-bit datapath words. Each lane holds
// its word and a valid flag until the downstream consumer acknowledges it.

module demux32_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_ack,
  output logic [31:0] o_data,
  output logic        o_valid
);
  logic [31:0] r_data;
  logic        r_valid;

  // A load in the same cycle as an ack wins, giving 1 word/cycle per lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ack && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

module demux32_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [31:0]      out_c,
  output logic [31:0]      out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [CNT_W-1:0] acc_count
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][31:0] w_lane_data;
  logic [NUM_LANES-1:0]       w_lane_vld;
  logic [NUM_LANES-1:0]       w_load;
  logic                       w_xfer;
  logic [CNT_W-1:0]           r_acc_cnt;

  // Readiness only looks at the selected lane, independent of in_valid.
  assign in_ready = ~w_lane_vld[in_sel] | out_ack[in_sel];
  assign w_xfer   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_load[gi] = w_xfer & (in_sel == 2'(gi));

      demux32_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[gi]),
        .i_data  (in_data),
        .i_ack   (out_ack[gi]),
        .o_data  (w_lane_data[gi]),
        .o_valid (w_lane_vld[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_acc_cnt <= '0;
    else if (w_xfer) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
  end

  assign out_a     = w_lane_data[0];
  assign out_b     = w_lane_data[1];
  assign out_c     = w_lane_data[2];
  assign out_d     = w_lane_data[3];
  assign out_valid = w_lane_vld;
  assign acc_count = r_acc_cnt;
endmodule

// File: tb/tb_demux32_reg.sv
// Directed bench for demux32_reg: accepted words are queued when driven and
// popped against the lane outputs after the accepting edge.

module tb_demux32_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a, out_b, out_c, out_d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack;
  logic [7:0]  acc_count;

  typedef struct {
    logic [1:0]  lane;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  demux32_reg #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .acc_count (acc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_out(input logic [1:0] lane);
    case (lane)
      2'd0:    return out_a;
      2'd1:    return out_b;
      2'd2:    return out_c;
      default: return out_d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a word the bench expects to be accepted at the next edge.
  task automatic send(input logic [1:0] sel, input logic [31:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    #1;
    chk("ready_before_send", 32'(in_ready), 32'd1);
    sb_q.push_back('{lane: sel, data: data});
  endtask

  task automatic pop_check(input string tag);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      it = sb_q.pop_front();
      chk({tag, "_data"}, lane_out(it.lane), it.data);
      chk({tag, "_vld"}, 32'(out_valid[it.lane]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ack = '0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_cnt", 32'(acc_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_c", out_c, 32'd0);
    chk("rst_out_d", out_d, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready_after", 32'(in_ready), 32'd1);

    // Single word to lane c
    send(2'd2, 32'hDEADBEEF);
    step(); in_valid = 1'b0;
    pop_check("lane_c");
    chk("c_valid_vec", 32'(out_valid), 32'h4);
    chk("c_cnt", 32'(acc_count), 32'd1);
    chk("c_out_a", out_a, 32'd0);
    chk("c_out_b", out_b, 32'd0);
    chk("c_out_d", out_d, 32'd0);

    // Lane b occupied, stall, then ack-and-load in the same cycle
    send(2'd1, 32'h11111111);
    step(); in_valid = 1'b0;
    pop_check("lane_b_first");
    in_sel = 2'd1; in_data = 32'h22222222; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(in_ready), 32'd0);
      step();
      chk("stall_hold_b", out_b, 32'h11111111);
      chk("stall_cnt", 32'(acc_count), 32'd2);
    end
    out_ack = 4'b0010;
    send(2'd1, 32'h22222222);
    step(); in_valid = 1'b0; out_ack = '0;
    pop_check("lane_b_replace");
    chk("b_replace_vec", 32'(out_valid), 32'h6);
    chk("b_replace_cnt", 32'(acc_count), 32'd3);
    chk("b_ack_keeps_c", out_c, 32'hDEADBEEF);

    // Back-to-back a,b,c,d,a with ack on lane a held, from a fresh reset
    rst = 1'b1; #1; rst = 1'b0;
    chk("rst2_cnt", 32'(acc_count), 32'd0);
    out_ack = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      send(2'(k % 4), 32'hA0000000 + 32'(k));
      step();
      pop_check("b2b");
    end
    in_valid = 1'b0; out_ack = '0;
    chk("b2b_out_a", out_a, 32'hA0000004);
    chk("b2b_cnt", 32'(acc_count), 32'd5);
    chk("b2b_vec", 32'(out_valid), 32'hF);

    // Ack on lane d empties it; a second ack on the empty lane is a no-op
    out_ack = 4'b1000; step(); out_ack = '0;
    chk("ack_d_vec", 32'(out_valid), 32'h7);
    out_ack = 4'b1000; step(); out_ack = '0;
    chk("ack_empty_vec", 32'(out_valid), 32'h7);
    chk("ack_empty_data", out_d, 32'hA0000003);
    chk("ack_empty_cnt", 32'(acc_count), 32'd5);

    // Asynchronous reset between edges with 3 lanes valid
    #2; rst = 1'b1; #1;
    chk("async_rst_vec", 32'(out_valid), 32'd0);
    chk("async_rst_cnt", 32'(acc_count), 32'd0);
    chk("async_rst_a", out_a, 32'd0);
    step(); rst = 1'b0;

    // Counter wrap after 256 accepted words
    out_ack = 4'b0001;
    for (int k = 0; k < 256; k++) begin
      send(2'd0, 32'h5000 + 32'(k));
      step();
      pop_check("wrap");
      if (k == 254) chk("cnt_255", 32'(acc_count), 32'd255);
    end
    in_valid = 1'b0; out_ack = '0;
    chk("cnt_wrap", 32'(acc_count), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
